// File: rtl/joy2quad_accel.sv
// Joystick button pairs to Gray-code quadrature streams, one per channel.
// Step period starts at clkdiv+1 cycles and halves per level while held.
module joy2quad_accel #(
  parameter int CHANNELS   = 2,
  parameter int DIV_W      = 32,
  parameter int ACCEL_MAX  = 3,
  parameter int HOLD_EDGES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic                  accel_en,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   moving
);

  localparam int LW = (ACCEL_MAX > 0) ? $clog2(ACCEL_MAX + 1) : 1;
  localparam int HW = (HOLD_EDGES > 1) ? $clog2(HOLD_EDGES) : 1;
  localparam logic [LW-1:0] LVL_MAX  = LW'(ACCEL_MAX);
  localparam logic [HW-1:0] HOLD_TOP = HW'(HOLD_EDGES - 1);

  typedef enum logic [1:0] {
    D_IDLE,
    D_LEFT,
    D_RIGHT
  } dir_e;

  function automatic logic [1:0] gray(input logic [1:0] p);
    logic [1:0] g;
    unique case (p)
      2'd0: g = 2'b00;
      2'd1: g = 2'b01;
      2'd2: g = 2'b11;
      default: g = 2'b10;
    endcase
    return g;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    dir_e             dir;
    dir_e             prev_d, prev_q;
    logic [1:0]       ph_d, ph_q;
    logic [DIV_W-1:0] cnt_d, cnt_q;
    logic [LW-1:0]    lvl_d, lvl_q, lvl_b;
    logic [HW-1:0]    hold_d, hold_q, hold_b;
    logic             mov_d, mov_q;
    logic             step;

    always_comb begin
      dir    = D_IDLE;
      prev_d = prev_q;
      ph_d   = ph_q;
      cnt_d  = cnt_q;
      lvl_d  = lvl_q;
      hold_d = hold_q;
      lvl_b  = lvl_q;
      hold_b = hold_q;
      step   = 1'b0;

      unique case (1'b1)
        left[c] & ~right[c]: dir = D_LEFT;
        right[c] & ~left[c]: dir = D_RIGHT;
        default:             dir = D_IDLE;
      endcase
      mov_d = (dir != D_IDLE);

      if (dir == D_IDLE) begin
        cnt_d  = '0;
        lvl_d  = '0;
        hold_d = '0;
        prev_d = D_IDLE;
      end else begin
        prev_d = dir;
        // A new press or reversal restarts acceleration and steps at once.
        if (dir != prev_q) begin
          lvl_b  = '0;
          hold_b = '0;
          step   = 1'b1;
        end else if (cnt_q == '0) begin
          step = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end

        if (step) begin
          ph_d = (dir == D_LEFT) ? ph_q + 2'd1 : ph_q - 2'd1;
          if (hold_b == HOLD_TOP) begin
            hold_d = '0;
            if (accel_en && lvl_b != LVL_MAX) begin
              lvl_d = lvl_b + LW'(1);
            end else begin
              lvl_d = lvl_b;
            end
          end else begin
            hold_d = hold_b + HW'(1);
            lvl_d  = lvl_b;
          end
          cnt_d = accel_en ? (clkdiv >> lvl_d) : clkdiv;
        end
      end

      if (!accel_en) begin
        lvl_d = '0;
      end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        prev_q <= D_IDLE;
        ph_q   <= '0;
        cnt_q  <= '0;
        lvl_q  <= '0;
        hold_q <= '0;
        mov_q  <= 1'b0;
      end else begin
        prev_q <= prev_d;
        ph_q   <= ph_d;
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        hold_q <= hold_d;
        mov_q  <= mov_d;
      end
    end

    assign steer[2*c +: 2] = gray(ph_q);
    assign moving[c]       = mov_q;
  end

endmodule

// File: tb/tb_joy2quad_accel.sv
// Directed bench for joy2quad_accel: expected steps are queued per channel
// with their edge index and Gray value, then matched as steer changes.
module tb_joy2quad_accel;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] clkdiv;
  logic        accel_en;
  logic [1:0]  left;
  logic [1:0]  right;
  logic [3:0]  steer;
  logic [1:0]  moving;

  typedef struct {
    int         t;
    logic [1:0] v;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  ph0;
  int  ph1;
  int  n_vec;
  int  n_bad;

  joy2quad_accel #(
    .CHANNELS  (2),
    .DIV_W     (32),
    .ACCEL_MAX (2),
    .HOLD_EDGES(4)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clkdiv  (clkdiv),
    .accel_en(accel_en),
    .left    (left),
    .right   (right),
    .steer   (steer),
    .moving  (moving)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [1:0] gray(input int p);
    logic [1:0] g;
    case (p & 3)
      0: g = 2'b00;
      1: g = 2'b01;
      2: g = 2'b11;
      default: g = 2'b10;
    endcase
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int t, input int d);
    ev_t e;
    e.t = t;
    if (c == 0) begin
      ph0 = (ph0 + d) & 3;
      e.v = gray(ph0);
      q0.push_back(e);
    end else begin
      ph1 = (ph1 + d) & 3;
      e.v = gray(ph1);
      q1.push_back(e);
    end
  endtask

  // Advance n edges; every steer change must match the next queued step.
  task automatic run(input string tag, input int n);
    logic [1:0] pv[2];
    logic [1:0] cur;
    ev_t        e;
    int         have;
    pv[0] = steer[1:0];
    pv[1] = steer[3:2];
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      for (int c = 0; c < 2; c++) begin
        cur = steer[2*c +: 2];
        if (cur !== pv[c]) begin
          have = (c == 0) ? q0.size() : q1.size();
          if (have == 0) begin
            chk($sformatf("%s_extra_ch%0d_k%0d", tag, c, k), 32'(cur),
                32'(pv[c]));
          end else begin
            e = (c == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("%s_time_ch%0d", tag, c), k, e.t);
            chk($sformatf("%s_val_ch%0d", tag, c), 32'(cur), 32'(e.v));
          end
          pv[c] = cur;
        end
      end
    end
    chk({tag, "_q0_left"}, q0.size(), 0);
    chk({tag, "_q1_left"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    int t3[13];
    n_vec    = 0;
    n_bad    = 0;
    ph0      = 0;
    ph1      = 0;
    RESET_N  = 1'b0;
    accel_en = 1'b0;
    clkdiv   = 32'd3;
    left     = 2'b11;
    right    = 2'b00;

    // Reset held across edges with buttons pressed.
    #12;
    chk("rst_steer", 32'(steer), 32'h0);
    chk("rst_moving", 32'(moving), 32'h0);
    left = 2'b00;
    #1 RESET_N = 1'b1;
    run("idle20", 20);
    chk("idle_steer", 32'(steer), 32'h0);

    // Fixed period, clkdiv=3: step every 4 edges.
    left = 2'b01;
    for (int i = 0; i < 5; i++) push(0, 4 * i, 1);
    run("fixed", 19);
    chk("fixed_moving", 32'(moving), 32'h1);
    left = 2'b00;
    run("release", 2);
    chk("release_steer", 32'(steer), 32'h1);
    chk("release_moving", 32'(moving), 32'h0);

    // Acceleration to saturation with right held.
    accel_en = 1'b1;
    clkdiv   = 32'd8;
    right    = 2'b01;
    t3 = '{0, 9, 18, 27, 32, 37, 42, 47, 50, 53, 56, 59, 62};
    for (int i = 0; i < 13; i++) push(0, t3[i], -1);
    run("accel", 64);
    right = 2'b00;
    run("gap", 1);

    // Six accelerated left steps, then direct reversal.
    left = 2'b01;
    push(0, 0, 1);
    push(0, 9, 1);
    push(0, 18, 1);
    push(0, 27, 1);
    push(0, 32, 1);
    push(0, 37, 1);
    run("pre_rev", 38);
    left  = 2'b00;
    right = 2'b01;
    push(0, 0, -1);
    push(0, 9, -1);
    run("rev", 12);

    // Both pressed on ch1 while ch0 runs.
    right = 2'b00;
    run("gap2", 1);
    left = 2'b10;
    push(1, 0, 1);
    run("ch1_tap", 1);
    chk("tap_moving", 32'(moving), 32'h2);
    accel_en = 1'b0;
    clkdiv   = 32'd4;
    left     = 2'b11;
    right    = 2'b10;
    for (int i = 0; i < 10; i++) push(0, 5 * i, 1);
    run("both", 50);
    chk("both_moving", 32'(moving), 32'h1);
    chk("both_ch1", 32'(steer[3:2]), 32'h1);

    // Asynchronous reset between edges with left[0] still held.
    right = 2'b00;
    left  = 2'b01;
    #1 RESET_N = 1'b0;
    #1;
    chk("midrst_steer", 32'(steer), 32'h0);
    chk("midrst_moving", 32'(moving), 32'h0);
    #1 RESET_N = 1'b1;
    ph0 = 0;
    ph1 = 0;
    push(0, 0, 1);
    push(0, 5, 1);
    run("post_rst", 7);
    chk("post_rst_moving", 32'(moving), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
